// File: rtl/pipe_rc_adder.sv
// Pipelined ripple-carry adder: WIDTH bits are split into STAGES ripple segments, one register per segment.
// Optional PIPE_RC_ADDER_OVF_EN adds a registered signed-overflow output (ovf).

module pipe_rc_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_RC_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CHUNK = WIDTH / STAGES;

    logic            advance;
    logic [STAGES:1] vld_pipe;

    // Whole pipe moves or holds as one; no per-stage skid.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (advance) begin
            for (int k = STAGES; k > 1; k--) vld_pipe[k] <= vld_pipe[k-1];
            vld_pipe[1] <= in_valid;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO = k * CHUNK;
        localparam int HI = LO + CHUNK;

        // Operand bits from this segment upward; lower bits are already summed.
        logic [WIDTH-1:LO] a_in;
        logic [WIDTH-1:LO] b_in;
        logic              c_in;
        logic [CHUNK-1:0]  s_chunk;
        logic              c_out;
        logic [HI-1:0]     s_nxt;
        logic [HI-1:0]     s_q;
        logic              c_q;

        if (k == 0) begin : g_head
            assign a_in  = a;
            assign b_in  = b;
            assign c_in  = cin;
            assign s_nxt = s_chunk;
        end else begin : g_body
            assign a_in  = stg[k-1].g_op.a_q;
            assign b_in  = stg[k-1].g_op.b_q;
            assign c_in  = stg[k-1].c_q;
            assign s_nxt = {s_chunk, stg[k-1].s_q};
        end

        pipe_rc_chunk #(.N(CHUNK)) u_chunk (
            .a  (a_in[HI-1:LO]),
            .b  (b_in[HI-1:LO]),
            .ci (c_in),
            .s  (s_chunk),
            .co (c_out)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (advance) begin
                s_q <= s_nxt;
                c_q <= c_out;
            end
        end

        if (k < STAGES-1) begin : g_op
            logic [WIDTH-1:HI] a_q;
            logic [WIDTH-1:HI] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[WIDTH-1:HI];
                    b_q <= b_in[WIDTH-1:HI];
                end
            end
        end
    end

    assign sum  = stg[STAGES-1].s_q;
    assign cout = stg[STAGES-1].c_q;

`ifdef PIPE_RC_ADDER_OVF_EN
    // Carry into the MSB recovered from its sum bit: c = a ^ b ^ s.
    logic c_msb;

    assign c_msb = stg[STAGES-1].a_in[WIDTH-1] ^ stg[STAGES-1].b_in[WIDTH-1]
                 ^ stg[STAGES-1].s_chunk[CHUNK-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ovf <= 1'b0;
        else if (advance) ovf <= c_msb ^ stg[STAGES-1].c_out;
    end
`endif

endmodule

module pipe_rc_chunk #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    logic [N:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < N; i++) begin : g_bit
        pipe_rc_fa u_fa (
            .x  (a[i]),
            .y  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co = c[N];
endmodule

module pipe_rc_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s0;
    logic c0;
    logic c1;

    pipe_rc_ha u_ha0 (.x(x),  .y(y),  .s(s0), .c(c0));
    pipe_rc_ha u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

    assign co = c0 | c1;
endmodule

module pipe_rc_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// File: tb/tb_pipe_rc_adder.sv
// Scoreboard bench for pipe_rc_adder: an 8-bit/2-stage and a 16-bit/4-stage instance against an arithmetic model.
// Build with PIPE_RC_ADDER_OVF_EN defined to also check ovf.

module tb_pipe_rc_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv8, ir8, ov8, or8, ci8, co8;
    logic [7:0]  a8, b8, s8;
    logic        iv16, ir16, ov16, or16, ci16, co16;
    logic [15:0] a16, b16, s16;
`ifdef PIPE_RC_ADDER_OVF_EN
    logic        of8, of16;
`endif

    typedef struct {
        int s;
        int co;
        int ov;
        int acc;
        bit lat;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   res16  = 0;

    pipe_rc_adder #(.WIDTH(8), .STAGES(2)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(ci8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8)
`ifdef PIPE_RC_ADDER_OVF_EN
        , .ovf(of8)
`endif
    );

    pipe_rc_adder #(.WIDTH(16), .STAGES(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(ci16),
        .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16)
`ifdef PIPE_RC_ADDER_OVF_EN
        , .ovf(of16)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Plain integer arithmetic: unsigned sum and signed range check for overflow.
    function automatic exp_t model(input int w, input int x, input int y, input int c,
                                   input int acc, input bit lat);
        exp_t e;
        int   t, h, sx, sy, st;
        h     = 1 << (w - 1);
        t     = x + y + c;
        e.s   = t % (1 << w);
        e.co  = t / (1 << w);
        sx    = (x >= h) ? x - 2 * h : x;
        sy    = (y >= h) ? y - 2 * h : y;
        st    = sx + sy + c;
        e.ov  = ((st >= h) || (st < -h)) ? 1 : 0;
        e.acc = acc;
        e.lat = lat;
        return e;
    endfunction

    task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic c, input bit lat);
        int n   = 0;
        bit acc = 1'b0;
        a8 = x; b8 = y; ci8 = c; iv8 = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            if (ir8) begin
                acc = 1'b1;
                q8.push_back(model(8, int'(x), int'(y), int'(c), cyc, lat));
            end
            @(posedge clk); #1;
            n++;
        end
        iv8 = 1'b0;
        chk("send8_accepted", int'(acc), 1);
    endtask

    task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic c, input bit lat);
        int n   = 0;
        bit acc = 1'b0;
        a16 = x; b16 = y; ci16 = c; iv16 = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            if (ir16) begin
                acc = 1'b1;
                q16.push_back(model(16, int'(x), int'(y), int'(c), cyc, lat));
            end
            @(posedge clk); #1;
            n++;
        end
        iv16 = 1'b0;
        chk("send16_accepted", int'(acc), 1);
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain8_pending", q8.size(), 0);
    endtask

    task automatic drain16();
        int n = 0;
        while (q16.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain16_pending", q16.size(), 0);
    endtask

    // Monitors: a result is consumed at the next edge whenever out_valid & out_ready.
    always @(negedge clk) begin
        if (rst_n && ov8 && or8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out8_unexpected: got sum 0x%0h with no beat outstanding", s8);
            end else begin
                chk("sum8", int'(s8), q8[0].s);
                chk("cout8", int'(co8), q8[0].co);
`ifdef PIPE_RC_ADDER_OVF_EN
                chk("ovf8", int'(of8), q8[0].ov);
`endif
                if (q8[0].lat) chk("latency8", cyc - q8[0].acc, 2);
                void'(q8.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov16 && or16) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out16_unexpected: got sum 0x%0h with no beat outstanding", s16);
            end else begin
                chk("sum16", int'(s16), q16[0].s);
                chk("cout16", int'(co16), q16[0].co);
`ifdef PIPE_RC_ADDER_OVF_EN
                chk("ovf16", int'(of16), q16[0].ov);
`endif
                if (q16[0].lat) chk("latency16", cyc - q16[0].acc, 4);
                void'(q16.pop_front());
                res16 <= res16 + 1;
            end
        end
    end

    // Stall behaviour: outputs frozen and in_ready low while a result waits.
    logic       pv8, pr8, pco8;
    logic [7:0] ps8;
    always @(negedge clk) begin
        if (rst_n && pv8 && !pr8) begin
            chk("stall_hold_valid8", int'(ov8), 1);
            chk("stall_hold_sum8", int'(s8), int'(ps8));
            chk("stall_hold_cout8", int'(co8), int'(pco8));
        end
        if (rst_n && ov8 && !or8) chk("stall_in_ready8", int'(ir8), 0);
        pv8  <= rst_n && ov8;
        pr8  <= or8;
        ps8  <= s8;
        pco8 <= co8;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; or8 = 1'b1;
        iv16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0; or16 = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid8", int'(ov8), 0);
        chk("rst_sum8", int'(s8), 0);
        chk("rst_cout8", int'(co8), 0);
        chk("rst_out_valid16", int'(ov16), 0);
        chk("rst_sum16", int'(s16), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready8", int'(ir8), 1);
        chk("post_rst_in_ready16", int'(ir16), 1);

        // Reset with two beats in flight: neither may ever come out.
        send8(8'h11, 8'h22, 1'b0, 1'b0);
        send8(8'h33, 8'h44, 1'b1, 1'b0);
        rst_n = 1'b0;
        q8.delete();
        #1;
        chk("midrst_out_valid8", int'(ov8), 0);
        chk("midrst_sum8", int'(s8), 0);
        chk("midrst_cout8", int'(co8), 0);
`ifdef PIPE_RC_ADDER_OVF_EN
        chk("midrst_ovf8", int'(of8), 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready8", int'(ir8), 1);
        chk("midrst_sum_after8", int'(s8), 0);
        chk("midrst_cout_after8", int'(co8), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_ghost8", int'(ov8), 0);

        // Directed: latency, cross-segment carry, wrap-around, overflow patterns.
        send8(8'h3C, 8'h05, 1'b0, 1'b1);
        drain8();
        send8(8'h0F, 8'h01, 1'b0, 1'b1);
        send8(8'hFF, 8'hFF, 1'b1, 1'b1);
        send8(8'h7F, 8'h01, 1'b0, 1'b1);
        send8(8'h80, 8'h80, 1'b0, 1'b1);
        send8(8'h10, 8'h20, 1'b0, 1'b1);
        drain8();

        // Backpressure: four beats with out_ready low for five cycles.
        or8 = 1'b0;
        fork
            begin
                send8(8'h01, 8'h01, 1'b0, 1'b0);
                send8(8'h10, 8'h10, 1'b0, 1'b0);
                send8(8'h7F, 8'h01, 1'b0, 1'b0);
                send8(8'hFF, 8'h01, 1'b0, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1 or8 = 1'b1;
            end
        join
        drain8();

        // Random operands under random backpressure.
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            end
            begin
                repeat (150) begin
                    @(posedge clk);
                    #1 or8 = 1'($urandom_range(0, 1));
                end
                or8 = 1'b1;
            end
        join
        drain8();

        // Full throughput on the 16-bit / 4-stage instance.
        send16(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        for (int i = 0; i < 255; i++)
            send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        drain16();
        chk("throughput16_count", res16, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
